// File: rtl/bitrev_deserializer_if.sv
// Handshake bundle for the bit-reversing deserializer: serial bit input side and word output side.
// The out_parity signal exists only when BITREV_PARITY_EN is defined.
interface bitrev_deserializer_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             in_bit;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    bit_cnt;
`ifdef BITREV_PARITY_EN
   logic             out_parity;

   modport master (
      output in_bit, in_valid, flush, out_ready,
      input  in_ready, out_data, out_valid, bit_cnt, out_parity
   );

   modport slave (
      input  in_bit, in_valid, flush, out_ready,
      output in_ready, out_data, out_valid, bit_cnt, out_parity
   );
`else
   modport master (
      output in_bit, in_valid, flush, out_ready,
      input  in_ready, out_data, out_valid, bit_cnt
   );

   modport slave (
      input  in_bit, in_valid, flush, out_ready,
      output in_ready, out_data, out_valid, bit_cnt
   );
`endif
endinterface

// File: rtl/bitrev_deserializer.sv
// Serial-to-parallel deserializer: first received bit lands in the MSB, one word of skid buffering.
// Optional registered word parity on out_parity when BITREV_PARITY_EN is defined.
//
// state   | meaning
// IDLE    | assembly register empty, bit_cnt = 0
// COLLECT | partial word, 0 < bit_cnt < WIDTH
// STALL   | full word held in assembly register, output register occupied, in_ready = 0
module bitrev_deserializer #(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   bitrev_deserializer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      STALL   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] asm_q, asm_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] out_data_q;
   logic             out_valid_q, out_valid_d;
   logic             load;
   logic [WIDTH-1:0] load_word;
   logic [WIDTH-1:0] shifted;
   logic             out_free;

   assign out_free = !out_valid_q || bus.out_ready;

   // Left shift: after WIDTH accepted bits the first one sits in the MSB.
   assign shifted = {asm_q[WIDTH-2:0], bus.in_bit};

   always_comb begin
      state_d   = state_q;
      asm_d     = asm_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      load_word = asm_q;
      if (bus.flush) begin
         state_d = IDLE;
         asm_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, COLLECT: begin
               if (bus.in_valid) begin
                  if (cnt_q == CW'(WIDTH - 1)) begin
                     if (out_free) begin
                        load      = 1'b1;
                        load_word = shifted;
                        asm_d     = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                     end else begin
                        asm_d   = shifted;
                        cnt_d   = CW'(WIDTH);
                        state_d = STALL;
                     end
                  end else begin
                     asm_d   = shifted;
                     cnt_d   = cnt_q + 1'b1;
                     state_d = COLLECT;
                  end
               end
            end
            STALL: begin
               if (bus.out_ready) begin
                  load      = 1'b1;
                  load_word = asm_q;
                  asm_d     = '0;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A load keeps out_valid high through a simultaneous drain, so there is no bubble.
   assign out_valid_d = load ? 1'b1 : (out_valid_q && !bus.out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         asm_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         asm_q       <= asm_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         if (load) out_data_q <= load_word;
      end
   end

`ifdef BITREV_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    parity_q <= 1'b0;
      else if (load) parity_q <= ^load_word;
   end

   assign bus.out_parity = parity_q;
`endif

   assign bus.in_ready  = (state_q != STALL);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_bitrev_deserializer.sv
// Self-checking bench for bitrev_deserializer: directed vector table, hand sequences, random vs. model.
module tb_bitrev_deserializer;
   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH + 1);

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   bitrev_deserializer_if #(.WIDTH(WIDTH)) bus ();

   bitrev_deserializer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            bit_i;
      logic            valid;
      logic            flush;
      logic            ready;
      logic            exp_valid;
      logic [WIDTH-1:0] exp_data;
      logic            exp_in_ready;
      logic [CW-1:0]   exp_cnt;
      logic            exp_par;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [WIDTH-1:0] ed,
                            input logic er, input logic [CW-1:0] ec, input logic ep);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
      check({tag, ".out_data"},  32'(bus.out_data),  32'(ed));
      check({tag, ".in_ready"},  32'(bus.in_ready),  32'(er));
      check({tag, ".bit_cnt"},   32'(bus.bit_cnt),   32'(ec));
`ifdef BITREV_PARITY_EN
      check({tag, ".out_parity"}, 32'(bus.out_parity), 32'(ep));
`else
      if (ep === 1'bx) check({tag, ".parity_unused"}, 32'(bus.out_valid), 32'(ev));
`endif
   endtask

   // Apply inputs, clock once, sample 1 time unit after the edge.
   task automatic tick(input logic b, input logic v, input logic f, input logic r);
      bus.in_bit    = b;
      bus.in_valid  = v;
      bus.flush     = f;
      bus.out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_bit = 0; bus.in_valid = 0; bus.flush = 0; bus.out_ready = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Behavioural reference: pending bits in arrival order, plus the visible output word.
   logic             m_bits[$];
   logic [WIDTH-1:0] m_data;
   logic             m_valid;

   function automatic logic [WIDTH-1:0] word_of(input logic q[$]);
      logic [WIDTH-1:0] w = '0;
      for (int k = 0; k < q.size(); k++) w[WIDTH-1-k] = q[k];
      return w;
   endfunction

   task automatic model_step(input logic b, input logic v, input logic f, input logic r);
      logic drain = m_valid && r;
      if (f) begin
         m_bits.delete();
         if (drain) m_valid = 0;
      end else if (m_bits.size() == WIDTH) begin
         if (drain) begin
            m_data = word_of(m_bits);
            m_bits.delete();
         end
      end else if (v) begin
         m_bits.push_back(b);
         if (m_bits.size() == WIDTH && (!m_valid || r)) begin
            m_data  = word_of(m_bits);
            m_valid = 1;
            m_bits.delete();
         end else if (drain) m_valid = 0;
      end else if (drain) m_valid = 0;
   endtask

   function automatic void add(input logic b, v, f, r, ev, input logic [WIDTH-1:0] ed,
                               input logic er, input logic [CW-1:0] ec);
      vec_t e;
      e.bit_i = b; e.valid = v; e.flush = f; e.ready = r;
      e.exp_valid = ev; e.exp_data = ed; e.exp_in_ready = er; e.exp_cnt = ec; e.exp_par = ^ed;
      vecs.push_back(e);
   endfunction

   initial begin
      logic [WIDTH-1:0] sent[3];
      logic [WIDTH-1:0] rev[3];
      logic [WIDTH-1:0] prev;

      // Words sent LSB-first and the bit-reversed result expected for each.
      sent[0] = 8'h01; rev[0] = 8'h80;
      sent[1] = 8'hA3; rev[1] = 8'hC5;
      sent[2] = 8'h0F; rev[2] = 8'hF0;
      prev = '0;
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < WIDTH; k++)
            add(sent[w][k], 1'b1, 1'b0, 1'b1, (k == WIDTH - 1),
                (k == WIDTH - 1) ? rev[w] : prev, 1'b1, CW'((k + 1) % WIDTH));
         prev = rev[w];
      end

      do_reset();
      check_all("reset", 1'b0, '0, 1'b1, '0, 1'b0);

      foreach (vecs[i]) begin
         tick(vecs[i].bit_i, vecs[i].valid, vecs[i].flush, vecs[i].ready);
         check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                   vecs[i].exp_in_ready, vecs[i].exp_cnt, vecs[i].exp_par);
      end

      // Backpressure: FF then 01 (LSB-first) with out_ready low.
      tick(0, 0, 0, 1);
      check("bp.drained", 32'(bus.out_valid), 32'd0);
      for (int k = 0; k < WIDTH; k++) tick(1, 1, 0, 0);
      check_all("bp.word1", 1'b1, 8'hFF, 1'b1, '0, 1'b0);
      for (int k = 0; k < WIDTH; k++) tick(k == 0, 1, 0, 0);
      check_all("bp.stall", 1'b1, 8'hFF, 1'b0, CW'(WIDTH), 1'b0);
      tick(1, 1, 0, 0);
      check_all("bp.hold", 1'b1, 8'hFF, 1'b0, CW'(WIDTH), 1'b0);
      tick(1, 1, 0, 1);
      check_all("bp.release", 1'b1, 8'h80, 1'b1, '0, 1'b1);
      tick(0, 0, 0, 1);
      check("bp.empty", 32'(bus.out_valid), 32'd0);

      // Flush after 5 bits with in_valid high, then a full word.
      for (int k = 0; k < 5; k++) tick(1, 1, 0, 1);
      check("fl.cnt5", 32'(bus.bit_cnt), 32'd5);
      tick(1, 1, 1, 1);
      check_all("fl.flushed", 1'b0, 8'h80, 1'b1, '0, 1'b1);
      begin
         logic [7:0] v3c = 8'h3C;
         for (int k = 0; k < WIDTH; k++) tick(v3c[k], 1, 0, 1);
      end
      check_all("fl.word", 1'b1, 8'h3C, 1'b1, '0, 1'b0);

      // Async reset mid-word with out_valid high.
      for (int k = 0; k < 3; k++) tick(1, 1, 0, 0);
      check("ar.pre_cnt", 32'(bus.bit_cnt), 32'd3);
      check("ar.pre_valid", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_all("ar.async", 1'b0, '0, 1'b1, '0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Random traffic against the reference model.
      do_reset();
      m_bits.delete(); m_data = '0; m_valid = 0;
      for (int c = 0; c < 3000; c++) begin
         logic b = 1'($urandom);
         logic v = ($urandom_range(0, 9) < 7);
         logic f = ($urandom_range(0, 49) == 0);
         logic r = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 6 : 2));
         tick(b, v, f, r);
         model_step(b, v, f, r);
         check_all($sformatf("rnd%0d", c), m_valid, m_data, (m_bits.size() != WIDTH),
                   CW'(m_bits.size()), ^m_data);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
